// File: rtl/accel_stream_pkg.sv
// Shared definitions for the accelerator width-converting streamers.
// Default lane geometry and lane offset helper used by aggregator/deaggregator.
package accel_stream_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FETCH_WIDTH = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } deagg_state_e;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/lane_mux.sv
// FETCH_WIDTH:1 select of one DATA_WIDTH lane from a packed wide word.
// Out-of-range selects return zero, so non-power-of-two widths are safe.
module lane_mux
  import accel_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int IDX_WIDTH   = $clog2(FETCH_WIDTH)
) (
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] data_i,
  input  logic [IDX_WIDTH-1:0]              sel_i,
  output logic [DATA_WIDTH-1:0]             data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (sel_i == IDX_WIDTH'(i)) begin
        data_o = data_i[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/deaggregator.sv
// Wide-to-narrow streamer: pops one wide word, emits its lanes lane 0 first.
// Define DEAGGREGATOR_LAST_EN to add the receiver_last output.
module deaggregator
  import accel_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int IDX_WIDTH   = $clog2(FETCH_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq
`ifdef DEAGGREGATOR_LAST_EN
  ,
  output logic                              receiver_last
`endif
);

  localparam int WW = FETCH_WIDTH * DATA_WIDTH;

  deagg_state_e         state_q, state_d;
  logic [WW-1:0]        buf_q, buf_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 valid_q;
  logic                 last;

  assign valid_q = (state_q == ST_DRAIN);
  assign last    = (idx_q == IDX_WIDTH'(FETCH_WIDTH - 1));

  assign receiver_enq = rst_n & valid_q & receiver_full_n;
  // Full receiver only reaches the sender via the last-lane reload term.
  assign sender_deq   = rst_n & sender_empty_n
                      & (~valid_q | (receiver_enq & last));

`ifdef DEAGGREGATOR_LAST_EN
  assign receiver_last = valid_q & last;
`endif

  lane_mux #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FETCH_WIDTH (FETCH_WIDTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_lane_mux (
    .data_i (buf_q),
    .sel_i  (idx_q),
    .data_o (receiver_data)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    if (sender_deq) begin
      buf_d   = sender_data;
      state_d = ST_DRAIN;
      idx_d   = '0;
    end else if (receiver_enq) begin
      if (last) begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_deaggregator.sv
// Scoreboard bench for deaggregator fed by a depth-3 sender fifo model.
// Stimulus pushes expected lanes; a negedge monitor pops and compares.
module tb_deaggregator;

  localparam int DW = 16;
  localparam int FW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [FW*DW-1:0] sender_data;
  logic           sender_empty_n;
  logic           sender_deq;
  logic [DW-1:0]  receiver_data;
  logic           receiver_full_n;
  logic           receiver_enq;
`ifdef DEAGGREGATOR_LAST_EN
  logic           receiver_last;
`endif

  always #5 clk = ~clk;

  deaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sender_data     (sender_data),
    .sender_empty_n  (sender_empty_n),
    .sender_deq      (sender_deq),
    .receiver_data   (receiver_data),
    .receiver_full_n (receiver_full_n),
    .receiver_enq    (receiver_enq)
`ifdef DEAGGREGATOR_LAST_EN
    ,
    .receiver_last   (receiver_last)
`endif
  );

  // sender fifo model: writer owns wr_cnt, pop side owns rd_cnt
  logic [FW*DW-1:0] fifo_mem [3];
  int  wr_cnt = 0;
  int  rd_cnt = 0;
  logic snd_en;

  assign sender_data    = fifo_mem[rd_cnt % 3];
  assign sender_empty_n = snd_en & ((wr_cnt - rd_cnt) > 0);

  always @(posedge clk) begin
    if (sender_deq) rd_cnt <= rd_cnt + 1;
  end

  // scoreboard
  logic [DW-1:0] exp_mem [4096];
  logic          exp_lst [4096];
  int exp_wr = 0;
  int exp_rd = 0;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic push_word(input logic [DW-1:0] base);
    logic [FW*DW-1:0] w;
    int guard;
    guard = 0;
    while ((wr_cnt - rd_cnt) >= 3 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("fifo_space_timeout", 1, 0);
    for (int i = 0; i < FW; i++) begin
      w[i*DW +: DW] = base + DW'(i);
      exp_mem[exp_wr % 4096] = base + DW'(i);
      exp_lst[exp_wr % 4096] = (i == FW - 1);
      exp_wr++;
    end
    fifo_mem[wr_cnt % 3] = w;
    wr_cnt++;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (exp_rd != exp_wr && k < 300);
    if (exp_rd != exp_wr) chk("drain_timeout", exp_wr - exp_rd, 0);
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_rd = exp_wr;
      end else if (receiver_enq) begin
        if (exp_rd == exp_wr) begin
          chk("unexpected_enq", receiver_data, 64'hdead);
        end else begin
          chk("rx_data", receiver_data, exp_mem[exp_rd % 4096]);
`ifdef DEAGGREGATOR_LAST_EN
          chk("rx_last", receiver_last, exp_lst[exp_rd % 4096]);
`endif
          exp_rd++;
        end
      end
    end
  end

  initial begin
    int v;
    int k;
    for (int i = 0; i < 3; i++) fifo_mem[i] = '0;
    rst_n = 1'b0;
    receiver_full_n = 1'b1;
    snd_en = 1'b1;

    // reset then idle
    @(negedge clk);
    chk("rst_enq", receiver_enq, 0);
    chk("rst_deq", sender_deq, 0);
    chk("rst_data", receiver_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_enq", receiver_enq, 0);
      chk("idle_deq", sender_deq, 0);
      chk("idle_data", receiver_data, 0);
    end

    // single word
    @(posedge clk); #1;
    push_word(16'd0);
    wait_drain();
    @(negedge clk);
    chk("single_enq_drop", receiver_enq, 0);

    // back-to-back: capture edges start cycles 0, 4, 8
    @(posedge clk); #1;
    push_word(16'd0);
    push_word(16'd4);
    push_word(16'd8);
    @(negedge clk);
    chk("b2b_deq_first", sender_deq, 1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("b2b_enq", receiver_enq, 1);
      chk("b2b_deq", sender_deq, (c == 3 || c == 7) ? 1 : 0);
    end
    wait_drain();

    // receiver stall on lane 1
    @(posedge clk); #1;
    push_word(16'd0);
    push_word(16'd4);
    @(negedge clk);
    chk("stall_deq_first", sender_deq, 1);
    @(negedge clk);
    chk("stall_lane0", receiver_data, 0);
    @(posedge clk); #1 receiver_full_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_enq", receiver_enq, 0);
      chk("stall_data", receiver_data, 1);
      chk("stall_deq", sender_deq, 0);
    end
    @(posedge clk); #1 receiver_full_n = 1'b1;
    wait_drain();

    // random stall on both sides
    v = 0;
    repeat (200) begin
      @(posedge clk); #1;
      receiver_full_n = ($urandom_range(0, 3) != 0);
      snd_en = ($urandom_range(0, 3) != 0);
      if ((wr_cnt - rd_cnt) < 3 && $urandom_range(0, 1) == 1) begin
        push_word(DW'(v));
        v += FW;
      end
    end
    @(posedge clk); #1;
    receiver_full_n = 1'b1;
    snd_en = 1'b1;
    wait_drain();

    // reset mid-drain
    @(posedge clk); #1;
    push_word(16'h10);
    @(negedge clk);
    chk("rmd_deq", sender_deq, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rmd_lane1", receiver_data, 16'h11);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rmd_enq_rst", receiver_enq, 0);
    chk("rmd_deq_rst", sender_deq, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rmd_enq_post", receiver_enq, 0);
    chk("rmd_data_post", receiver_data, 0);
    @(posedge clk); #1;
    push_word(16'h20);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!receiver_enq && k < 20);
    chk("rmd_first", receiver_data, 16'h20);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
